// File: rtl/cs_pkg.sv
// cs_pkg: shared constants and the FIFO word type for the CS result path.
//   CS_DATA_W   - width of a CS averaging-stage result sample
//   CS_SEQ_W    - width of the wrapping sequence tag
//   cs_result_t - stored FIFO word {seq, data}
package cs_pkg;

   localparam int CS_DATA_W = 10;
   localparam int CS_SEQ_W  = 8;

   typedef struct packed {
      logic [CS_SEQ_W-1:0]  seq;
      logic [CS_DATA_W-1:0] data;
   } cs_result_t;

endpackage

// File: rtl/cs_fifo_sync.sv
// cs_fifo_sync: generic synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (flushes contents)
//   push, wdata - write request and word; caller must not push when full
//                 unless it pops in the same cycle
//   pop         - consume head entry; ignored when empty
//   rdata       - head entry, forced to 0 when empty
//   full, empty - status flags
//   level       - number of stored entries, 0..DEPTH
module cs_fifo_sync #(
   parameter int W     = 18,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             do_pop;

   assign empty  = (count == '0);
   assign full   = (count == LVL_W'(DEPTH));
   assign level  = count;
   assign do_pop = pop & ~empty;
   // Head is read straight from the storage registers; no path from wdata.
   assign rdata  = empty ? '0 : mem[rd_ptr];

   // Storage is not reset: contents are meaningless until counted in.
   always_ff @(posedge clk) begin
      if (!reset && push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !do_pop)
            count <= count + LVL_W'(1);
         else if (!push && do_pop)
            count <= count - LVL_W'(1);
      end
   end

endmodule

// File: rtl/cs_result_fifo.sv
// cs_result_fifo: buffers CS result samples, tagging each with a wrapping
// sequence number, and releases them over a valid/ready handshake.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   y_in, y_valid       - result stream from the CS stage (no backpressure)
//   out_data, out_seq   - head entry (0 when out_valid=0)
//   out_valid/out_ready - output handshake; pop = out_valid & out_ready
//   level               - stored entry count, 0..DEPTH
//   overflow, clr_ovf   - sticky drop flag and its clear (set wins)
//   peak                - largest y_in seen with y_valid since reset
module cs_result_fifo
   import cs_pkg::*;
#(
   parameter int DATA_W = CS_DATA_W,
   parameter int SEQ_W  = CS_SEQ_W,
   parameter int DEPTH  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_W-1:0]      y_in,
   input  logic                   y_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic [SEQ_W-1:0]       out_seq,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   input  logic                   clr_ovf,
   output logic [DATA_W-1:0]      peak
);

   cs_result_t       wr_word;
   cs_result_t       head;
   logic [SEQ_W-1:0] seq;
   logic             full;
   logic             empty;
   logic             pop;
   logic             accept;
   logic             drop;

   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   // A full FIFO still takes a sample when the head leaves in the same cycle.
   assign accept    = y_valid & (~full | pop);
   assign drop      = y_valid & full & ~pop;

   assign wr_word.seq  = seq;
   assign wr_word.data = y_in;
   assign out_data     = head.data;
   assign out_seq      = head.seq;

   cs_fifo_sync #(
      .W     ($bits(cs_result_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .wdata (wr_word),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // seq advances on dropped samples too, so gaps in out_seq mark losses.
   always_ff @(posedge clk) begin
      if (reset) begin
         seq      <= '0;
         overflow <= 1'b0;
         peak     <= '0;
      end else begin
         if (y_valid)
            seq <= seq + SEQ_W'(1);
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
         if (y_valid && (y_in > peak))
            peak <= y_in;
      end
   end

endmodule

// File: tb/tb_cs_result_fifo.sv
// tb_cs_result_fifo: directed self-checking bench for cs_result_fifo.
module tb_cs_result_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] y_in;
   logic       y_valid;
   logic [9:0] out_data;
   logic [7:0] out_seq;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] level;
   logic       overflow;
   logic       clr_ovf;
   logic [9:0] peak;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cs_result_fifo dut (
      .clk       (clk),
      .reset     (reset),
      .y_in      (y_in),
      .y_valid   (y_valid),
      .out_data  (out_data),
      .out_seq   (out_seq),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf),
      .peak      (peak)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; y_in = '0; y_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_peak", peak, 0);
      chk("rst_data", out_data, 0);
      chk("rst_seq", out_seq, 0);

      // Three samples, consumer stalled
      y_valid = 1'b1; y_in = 10'd100; tick();
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 100);
      chk("t1_seq", out_seq, 0);
      y_in = 10'd101; tick();
      y_in = 10'd102; tick();
      y_valid = 1'b0;
      chk("t1_level", level, 3);
      chk("t1_data_hold", out_data, 100);

      // Drain at one per cycle
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("t2_valid", out_valid, 1);
         chk("t2_data", out_data, 100 + i);
         chk("t2_seq", out_seq, i);
         tick();
      end
      chk("t2_empty", out_valid, 0);
      chk("t2_level", level, 0);
      chk("t2_data0", out_data, 0);
      out_ready = 1'b0;

      reset = 1'b1; tick(); reset = 1'b0;

      // Fill, then overflow
      y_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         y_in = 10'(10 + i); tick();
      end
      chk("t3_full_level", level, 8);
      chk("t3_ovf_pre", overflow, 0);
      y_in = 10'd500; tick();
      y_valid = 1'b0;
      chk("t3_ovf", overflow, 1);
      chk("t3_level", level, 8);
      chk("t3_peak", peak, 500);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t3_drain_seq", out_seq, i);
         chk("t3_drain_data", out_data, 10 + i);
         tick();
      end
      chk("t3_drained", level, 0);
      out_ready = 1'b0;
      y_valid = 1'b1; y_in = 10'd7; tick();
      y_valid = 1'b0;
      chk("t3_gap_seq", out_seq, 9);
      chk("t3_gap_data", out_data, 7);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("t3_empty", out_valid, 0);

      // Refill (seq 10..17), drop with clr_ovf: set wins
      y_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         y_in = 10'(20 + i); tick();
      end
      clr_ovf = 1'b1; y_in = 10'd30; tick();
      chk("t5_set_wins", overflow, 1);
      y_valid = 1'b0; tick();
      clr_ovf = 1'b0;
      chk("t5_cleared", overflow, 0);
      chk("t5_level", level, 8);

      // Full with simultaneous push and pop (seq 19)
      y_valid = 1'b1; out_ready = 1'b1; y_in = 10'd777; tick();
      y_valid = 1'b0;
      chk("t4_level", level, 8);
      chk("t4_ovf", overflow, 0);
      for (int i = 0; i < 7; i++) begin
         chk("t4_drain_seq", out_seq, 11 + i);
         tick();
      end
      chk("t4_last_seq", out_seq, 19);
      chk("t4_last_data", out_data, 777);
      tick();
      chk("t4_empty", out_valid, 0);
      out_ready = 1'b0;

      // Peak and mid-stream reset
      y_valid = 1'b1;
      y_in = 10'd300;  tick();
      y_in = 10'd1023; tick();
      y_in = 10'd5;    tick();
      chk("t6_peak", peak, 1023);
      chk("t6_level", level, 3);
      reset = 1'b1; y_in = 10'd50; tick();
      reset = 1'b0; y_valid = 1'b0;
      chk("t6_rst_peak", peak, 0);
      chk("t6_rst_level", level, 0);
      chk("t6_rst_valid", out_valid, 0);
      y_valid = 1'b1; y_in = 10'd60; tick();
      y_valid = 1'b0;
      chk("t6_seq0", out_seq, 0);
      chk("t6_data", out_data, 60);
      chk("t6_peak2", peak, 60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
